// File: rtl/ad9783_driver.sv
// AD9783 dual-DAC driver: forwarded clock, DDR sample bus with DCI strobe,
// SPI register access and DAC hardware-reset control from a command port.
module ad9783_driver #(
  parameter int SPI_HALF   = 4,
  parameter int RST_CYCLES = 16
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cmd_trig_in,
  input  logic [15:0] cmd_addr_in,
  input  logic [15:0] cmd_data_in,
  output logic [15:0] cmd_data_out,
  output logic        rst_out,
  output logic        spi_scs_out,
  output logic        spi_sck_out,
  output logic        spi_sdo_out,
  input  logic        spi_sdi_in,
  input  logic [15:0] DAC0_in,
  input  logic [15:0] DAC1_in,
  output logic        CLK_out_p,
  output logic        CLK_out_n,
  output logic        DCI_out_p,
  output logic        DCI_out_n,
  output logic [15:0] D_out_p,
  output logic [15:0] D_out_n
);

  localparam int DW = (SPI_HALF > 1) ? $clog2(SPI_HALF) : 1;
  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SPI_HALF - 1);
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} spi_state_e;

  spi_state_e    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          ph_q, ph_d;
  logic [3:0]    bit_q, bit_d;
  logic [15:0]   sh_q, sh_d;
  logic          is_rd_q, is_rd_d;
  logic [7:0]    rd_sh_q, rd_sh_d;
  logic [7:0]    rd_byte_q, rd_byte_d;
  logic [CW-1:0] rst_cnt_q, rst_cnt_d;
  logic          rst_out_q, rst_out_d;
  logic [15:0]   dac0_q, dac1_q;
  logic          dci_en_q;

  logic busy, cmd_ok, spi_go, rst_go, div_last;
  logic unused_bits;

  // Command handshake: cmd_trig_in is a one-cycle valid; the port is ready
  // only while the SPI engine is idle, and a strobe seen while busy is lost.
  assign busy     = (state_q != ST_IDLE);
  assign cmd_ok   = cmd_trig_in && !busy;
  assign spi_go   = cmd_ok && (cmd_addr_in == 16'h0000 || cmd_addr_in == 16'h0001);
  assign rst_go   = cmd_ok && (cmd_addr_in == 16'h0002);
  assign div_last = (div_q == DIV_LAST);
  assign unused_bits = ^cmd_data_in[15:13];

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= ST_IDLE;
      div_q     <= '0;
      ph_q      <= 1'b0;
      bit_q     <= '0;
      sh_q      <= '0;
      is_rd_q   <= 1'b0;
      rd_sh_q   <= '0;
      rd_byte_q <= '0;
      rst_cnt_q <= '0;
      rst_out_q <= 1'b1;
      dac0_q    <= '0;
      dac1_q    <= '0;
      dci_en_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      ph_q      <= ph_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      is_rd_q   <= is_rd_d;
      rd_sh_q   <= rd_sh_d;
      rd_byte_q <= rd_byte_d;
      rst_cnt_q <= rst_cnt_d;
      rst_out_q <= rst_out_d;
      dac0_q    <= DAC0_in;
      dac1_q    <= DAC1_in;
      dci_en_q  <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (spi_go) state_d = ST_SETUP;
      ST_SETUP: if (div_last) state_d = ST_SHIFT;
      ST_SHIFT: if (div_last && ph_q && bit_q == 4'd15) state_d = ST_HOLD;
      ST_HOLD:  if (div_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // SCK phase timing, shift registers and readback capture
  always_comb begin
    div_d     = div_q;
    ph_d      = ph_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    is_rd_d   = is_rd_q;
    rd_sh_d   = rd_sh_q;
    rd_byte_d = rd_byte_q;
    if (state_q == ST_IDLE) begin
      div_d = '0;
      ph_d  = 1'b0;
      bit_d = '0;
      if (spi_go) begin
        sh_d    = {cmd_addr_in[0], 2'b00, cmd_data_in[12:8],
                   cmd_addr_in[0] ? 8'h00 : cmd_data_in[7:0]};
        is_rd_d = cmd_addr_in[0];
        rd_sh_d = '0;
      end
    end else begin
      div_d = div_last ? '0 : div_q + 1'b1;
      if (state_q == ST_SHIFT && div_last) begin
        ph_d = ~ph_q;
        // ph_q low -> SCK about to rise (sample); high -> about to fall (shift)
        if (!ph_q) begin
          if (bit_q[3]) rd_sh_d = {rd_sh_q[6:0], spi_sdi_in};
        end else begin
          sh_d  = {sh_q[14:0], 1'b0};
          bit_d = bit_q + 1'b1;
        end
      end
      if (state_q == ST_HOLD && div_last && is_rd_q) rd_byte_d = rd_sh_q;
    end
  end

  // DAC reset line: auto-release counter, overridable by command 0x0002
  always_comb begin
    rst_cnt_d = rst_cnt_q;
    rst_out_d = rst_out_q;
    if (rst_cnt_q != RST_LAST) begin
      rst_cnt_d = rst_cnt_q + 1'b1;
      if (rst_cnt_q == RST_LAST - 1'b1) rst_out_d = 1'b0;
    end
    if (rst_go) begin
      rst_out_d = cmd_data_in[0];
      rst_cnt_d = RST_LAST;
    end
  end

  // Outputs
  always_comb begin
    spi_scs_out  = (state_q == ST_IDLE);
    spi_sck_out  = (state_q == ST_SHIFT) && ph_q;
    spi_sdo_out  = busy && sh_q[15];
    cmd_data_out = {busy, 7'b0, rd_byte_q};
    rst_out      = rst_out_q;
  end

  // ODDR-style DDR mux: DAC0 word while clk_in is high, DAC1 while low
  assign CLK_out_p = clk_in;
  assign CLK_out_n = ~clk_in;
  assign DCI_out_p = clk_in & dci_en_q;
  assign DCI_out_n = ~DCI_out_p;
  assign D_out_p   = clk_in ? dac0_q : dac1_q;
  assign D_out_n   = ~D_out_p;

endmodule

// File: tb/tb_ad9783_driver.sv
// Bench for ad9783_driver: DDR datapath, SPI frames against an SDI model,
// reset-line control and reset abort.
module tb_ad9783_driver;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        cmd_trig_in;
  logic [15:0] cmd_addr_in, cmd_data_in;
  logic [15:0] cmd_data_out;
  logic        rst_out, spi_scs_out, spi_sck_out, spi_sdo_out, spi_sdi_in;
  logic [15:0] DAC0_in, DAC1_in;
  logic        CLK_out_p, CLK_out_n, DCI_out_p, DCI_out_n;
  logic [15:0] D_out_p, D_out_n;

  int pass_cnt = 0;
  int total_cnt = 0;

  ad9783_driver dut (
    .clk_in(clk_in), .rst_in(rst_in), .cmd_trig_in(cmd_trig_in),
    .cmd_addr_in(cmd_addr_in), .cmd_data_in(cmd_data_in), .cmd_data_out(cmd_data_out),
    .rst_out(rst_out), .spi_scs_out(spi_scs_out), .spi_sck_out(spi_sck_out),
    .spi_sdo_out(spi_sdo_out), .spi_sdi_in(spi_sdi_in),
    .DAC0_in(DAC0_in), .DAC1_in(DAC1_in),
    .CLK_out_p(CLK_out_p), .CLK_out_n(CLK_out_n),
    .DCI_out_p(DCI_out_p), .DCI_out_n(DCI_out_n),
    .D_out_p(D_out_p), .D_out_n(D_out_n)
  );

  // Clock / reset
  always #5 clk_in = ~clk_in;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // SDI model: DAC returns sdi_resp MSB first during bits 8-15, changing on SCK fall
  logic [7:0] sdi_resp = 8'h00;
  int sdi_cnt = 0;
  always @(negedge spi_sck_out or posedge spi_scs_out) begin
    if (spi_scs_out) sdi_cnt <= 0;
    else sdi_cnt <= sdi_cnt + 1;
  end
  always_comb begin
    spi_sdi_in = 1'b0;
    if (!spi_scs_out && sdi_cnt >= 8 && sdi_cnt < 16) spi_sdi_in = sdi_resp[15 - sdi_cnt];
  end

  // Frame monitor
  logic [15:0] mon_bits = '0;
  int mon_rises = 0;
  always @(posedge spi_sck_out) begin
    mon_bits  <= {mon_bits[14:0], spi_sdo_out};
    mon_rises <= mon_rises + 1;
  end

  logic       scs_prev = 1'b1;
  int         mon_low = 0, mon_low_last = 0, rises_base = 0, rises_last = 0;
  int         frames_done = 0, busy_err = 0;
  logic [7:0] mon_pre_rd = '0, mon_end_rd = '0;
  always @(negedge clk_in) begin
    if (cmd_data_out[15] !== !spi_scs_out) busy_err++;
    if (spi_scs_out === 1'b0) begin
      if (scs_prev) begin
        mon_low = 0;
        rises_base = mon_rises;
      end
      mon_low++;
      mon_pre_rd = cmd_data_out[7:0];
    end else if (!scs_prev) begin
      mon_low_last = mon_low;
      rises_last = mon_rises - rises_base;
      mon_end_rd = cmd_data_out[7:0];
      frames_done++;
    end
    scs_prev = spi_scs_out;
  end

  logic [7:0] rb_model = 8'h00;

  // Driver tasks
  task automatic issue_cmd(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk_in);
    cmd_addr_in = addr;
    cmd_data_in = data;
    cmd_trig_in = 1'b1;
    @(posedge clk_in);
    #1 cmd_trig_in = 1'b0;
  endtask

  task automatic wait_frame(input int base, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_in);
      #1;
      if (frames_done != base) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    int fall_at;
    rst_in = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    total_cnt++; if (D_out_p !== 16'h0000) $display("FAIL rst_d_p got %h exp 0000", D_out_p); else pass_cnt++;
    total_cnt++; if (D_out_n !== 16'hFFFF) $display("FAIL rst_d_n got %h exp ffff", D_out_n); else pass_cnt++;
    total_cnt++; if ({DCI_out_p, DCI_out_n} !== 2'b01) $display("FAIL rst_dci got %b exp 01", {DCI_out_p, DCI_out_n}); else pass_cnt++;
    total_cnt++; if (cmd_data_out !== 16'h0000) $display("FAIL rst_cmd_data got %h exp 0000", cmd_data_out); else pass_cnt++;
    total_cnt++; if ({rst_out, spi_scs_out, spi_sck_out, spi_sdo_out} !== 4'b1100)
      $display("FAIL rst_ctrl got %b exp 1100", {rst_out, spi_scs_out, spi_sck_out, spi_sdo_out}); else pass_cnt++;
    @(negedge clk_in);
    rst_in = 1'b1;
    fall_at = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk_in);
      #1;
      if (rst_out === 1'b0) begin
        fall_at = n;
        break;
      end
    end
    total_cnt++; if (fall_at != 16) $display("FAIL rst_out_release got %0d exp 16", fall_at); else pass_cnt++;
    total_cnt++; if (D_out_p !== 16'h0000 || D_out_n !== 16'hFFFF) $display("FAIL post_rst_d got %h/%h exp 0000/ffff", D_out_p, D_out_n); else pass_cnt++;
  endtask

  task automatic test_reset_abort;
    int base;
    sdi_resp = 8'h5A;
    issue_cmd(16'h0001, 16'h0500);
    repeat (50) @(posedge clk_in);
    #2 rst_in = 1'b0;
    #1;
    total_cnt++; if (spi_scs_out !== 1'b1 || spi_sck_out !== 1'b0) $display("FAIL abort_scs got scs=%b sck=%b exp 1/0", spi_scs_out, spi_sck_out); else pass_cnt++;
    total_cnt++; if (cmd_data_out !== 16'h0000) $display("FAIL abort_rd got %h exp 0000", cmd_data_out); else pass_cnt++;
    @(negedge clk_in);
    rst_in = 1'b1;
    #1 base = frames_done;
    repeat (200) @(posedge clk_in);
    #1;
    total_cnt++; if (cmd_data_out !== 16'h0000) $display("FAIL abort_no_update got %h exp 0000", cmd_data_out); else pass_cnt++;
    total_cnt++; if (frames_done != base) $display("FAIL abort_no_frame got %0d exp %0d", frames_done, base); else pass_cnt++;
    total_cnt++; if (rst_out !== 1'b0) $display("FAIL abort_rst_out got %b exp 0", rst_out); else pass_cnt++;
  endtask

  task automatic test_datapath;
    logic [31:0] exp_q[$];
    logic [31:0] e;
    logic [15:0] sweep [3];
    sweep[0] = 16'hFFFF; sweep[1] = 16'hFFEF; sweep[2] = 16'hFFE1;
    @(negedge clk_in);
    for (int i = 0; i < 90; i++) begin
      if (i < 60) begin
        DAC0_in = sweep[i / 20];
        DAC1_in = 16'h0000;
      end else begin
        DAC0_in = 16'($urandom);
        DAC1_in = 16'($urandom);
      end
      exp_q.push_back({DAC0_in, DAC1_in});
      @(posedge clk_in);
      #1 e = exp_q.pop_front();
      total_cnt++; if (D_out_p !== e[31:16] || D_out_n !== ~e[31:16])
        $display("FAIL dp_high got %h/%h exp %h/%h", D_out_p, D_out_n, e[31:16], ~e[31:16]); else pass_cnt++;
      total_cnt++; if ({DCI_out_p, DCI_out_n, CLK_out_p, CLK_out_n} !== 4'b1010)
        $display("FAIL dci_high got %b exp 1010", {DCI_out_p, DCI_out_n, CLK_out_p, CLK_out_n}); else pass_cnt++;
      @(negedge clk_in);
      #1;
      total_cnt++; if (D_out_p !== e[15:0] || D_out_n !== ~e[15:0])
        $display("FAIL dp_low got %h/%h exp %h/%h", D_out_p, D_out_n, e[15:0], ~e[15:0]); else pass_cnt++;
      total_cnt++; if ({DCI_out_p, DCI_out_n, CLK_out_p, CLK_out_n} !== 4'b0101)
        $display("FAIL dci_low got %b exp 0101", {DCI_out_p, DCI_out_n, CLK_out_p, CLK_out_n}); else pass_cnt++;
    end
  endtask

  task automatic test_spi_write;
    int base;
    logic ok;
    base = frames_done;
    @(negedge clk_in);
    cmd_addr_in = 16'h0000;
    cmd_data_in = 16'h0A5C;
    cmd_trig_in = 1'b1;
    #1;
    total_cnt++; if (cmd_data_out[15] !== 1'b0) $display("FAIL wr_busy_pre got %b exp 0", cmd_data_out[15]); else pass_cnt++;
    @(posedge clk_in);
    #1 cmd_trig_in = 1'b0;
    total_cnt++; if (cmd_data_out[15] !== 1'b1 || spi_scs_out !== 1'b0)
      $display("FAIL wr_busy_rise got busy=%b scs=%b exp 1/0", cmd_data_out[15], spi_scs_out); else pass_cnt++;
    wait_frame(base, ok);
    total_cnt++; if (!ok) $display("FAIL wr_frame_timeout got none exp frame"); else pass_cnt++;
    total_cnt++; if (mon_bits !== 16'h0A5C) $display("FAIL wr_bits got %h exp 0a5c", mon_bits); else pass_cnt++;
    total_cnt++; if (rises_last != 16) $display("FAIL wr_sck_rises got %0d exp 16", rises_last); else pass_cnt++;
    total_cnt++; if (mon_low_last != 136) $display("FAIL wr_scs_low got %0d exp 136", mon_low_last); else pass_cnt++;
    total_cnt++; if (busy_err != 0) $display("FAIL wr_busy_track got %0d exp 0", busy_err); else pass_cnt++;
  endtask

  task automatic test_spi_read;
    int base;
    logic ok;
    base = frames_done;
    sdi_resp = 8'hC3;
    issue_cmd(16'h0001, 16'h1F00);
    wait_frame(base, ok);
    rb_model = 8'hC3;
    total_cnt++; if (!ok) $display("FAIL rd_frame_timeout got none exp frame"); else pass_cnt++;
    total_cnt++; if (mon_bits[15:8] !== 8'h9F) $display("FAIL rd_instr got %h exp 9f", mon_bits[15:8]); else pass_cnt++;
    total_cnt++; if (mon_pre_rd !== 8'h00) $display("FAIL rd_pre got %h exp 00", mon_pre_rd); else pass_cnt++;
    total_cnt++; if (mon_end_rd !== 8'hC3) $display("FAIL rd_end got %h exp c3", mon_end_rd); else pass_cnt++;
    total_cnt++; if (cmd_data_out !== 16'h00C3) $display("FAIL rd_data_out got %h exp 00c3", cmd_data_out); else pass_cnt++;
  endtask

  task automatic test_busy_drop;
    int base;
    logic ok;
    base = frames_done;
    issue_cmd(16'h0000, 16'h1234);
    repeat (10) @(posedge clk_in);
    issue_cmd(16'h0000, 16'h0BEE);
    issue_cmd(16'h0002, 16'h0001);
    repeat (30) @(posedge clk_in);
    issue_cmd(16'h0001, 16'h0011);
    wait_frame(base, ok);
    total_cnt++; if (!ok) $display("FAIL drop_frame_timeout got none exp frame"); else pass_cnt++;
    total_cnt++; if (mon_bits !== 16'h1234) $display("FAIL drop_bits got %h exp 1234", mon_bits); else pass_cnt++;
    repeat (300) @(posedge clk_in);
    #1;
    total_cnt++; if (frames_done != base + 1) $display("FAIL drop_frames got %0d exp %0d", frames_done - base, 1); else pass_cnt++;
    total_cnt++; if (rst_out !== 1'b0) $display("FAIL drop_rst_cmd got %b exp 0", rst_out); else pass_cnt++;
    total_cnt++; if (cmd_data_out !== {8'h00, rb_model}) $display("FAIL drop_rd got %h exp %h", cmd_data_out, {8'h00, rb_model}); else pass_cnt++;
  endtask

  task automatic test_rst_cmd;
    int base;
    logic [15:0] junk;
    issue_cmd(16'h0002, 16'h0001);
    total_cnt++; if (rst_out !== 1'b1 || cmd_data_out[15] !== 1'b0)
      $display("FAIL rstcmd_set got rst=%b busy=%b exp 1/0", rst_out, cmd_data_out[15]); else pass_cnt++;
    repeat (20) @(posedge clk_in);
    #1;
    total_cnt++; if (rst_out !== 1'b1) $display("FAIL rstcmd_hold got %b exp 1", rst_out); else pass_cnt++;
    issue_cmd(16'h0002, 16'hFFFE);
    total_cnt++; if (rst_out !== 1'b0) $display("FAIL rstcmd_clr got %b exp 0", rst_out); else pass_cnt++;
    base = frames_done;
    junk = 16'($urandom_range(3, 16'hFFFF));
    issue_cmd(junk, 16'hFFFF);
    repeat (150) @(posedge clk_in);
    #1;
    total_cnt++; if (frames_done != base || rst_out !== 1'b0 || cmd_data_out !== {8'h00, rb_model})
      $display("FAIL other_addr got frames=%0d rst=%b data=%h exp 0/0/%h", frames_done - base, rst_out, cmd_data_out, {8'h00, rb_model}); else pass_cnt++;
  endtask

  task automatic test_random_spi;
    int base;
    logic ok, is_rd;
    logic [15:0] d, exp_bits;
    logic [7:0] prev_rb;
    for (int i = 0; i < 8; i++) begin
      is_rd = 1'($urandom_range(0, 1));
      d = 16'($urandom);
      sdi_resp = 8'($urandom);
      prev_rb = rb_model;
      exp_bits = {is_rd, 2'b00, d[12:8], d[7:0]};
      if (is_rd) rb_model = sdi_resp;
      base = frames_done;
      issue_cmd({15'h0, is_rd}, d);
      wait_frame(base, ok);
      total_cnt++; if (!ok) $display("FAIL rnd_timeout iter %0d", i); else pass_cnt++;
      total_cnt++; if (mon_bits[15:8] !== exp_bits[15:8] || (!is_rd && mon_bits[7:0] !== exp_bits[7:0]))
        $display("FAIL rnd_bits got %h exp %h rd=%b", mon_bits, exp_bits, is_rd); else pass_cnt++;
      total_cnt++; if (mon_low_last != 136 || rises_last != 16)
        $display("FAIL rnd_len got %0d/%0d exp 136/16", mon_low_last, rises_last); else pass_cnt++;
      total_cnt++; if (mon_pre_rd !== prev_rb || mon_end_rd !== rb_model)
        $display("FAIL rnd_rd got %h->%h exp %h->%h", mon_pre_rd, mon_end_rd, prev_rb, rb_model); else pass_cnt++;
      repeat ($urandom_range(0, 5)) @(posedge clk_in);
    end
    total_cnt++; if (busy_err != 0) $display("FAIL busy_track got %0d exp 0", busy_err); else pass_cnt++;
  endtask

  initial begin
    rst_in = 1'b0;
    cmd_trig_in = 1'b0;
    cmd_addr_in = '0;
    cmd_data_in = '0;
    DAC0_in = '0;
    DAC1_in = '0;
    test_reset;
    test_reset_abort;
    test_datapath;
    test_spi_write;
    test_spi_read;
    test_busy_drop;
    test_rst_cmd;
    test_random_spi;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
